// File: rtl/ps2_scan_decoder.sv
// PS/2 scan code set 2 decoder: folds E0/F0/E1 prefixes into single key events behind a one-entry holding register.
// Optional typematic repeat filter enabled by defining PS2_SCAN_DECODER_REPEAT_FILTER_EN.
//
// state  | meaning
// IDLE   | waiting for the first byte of a sequence
// EXT    | got E0
// BRK    | got F0
// EXTBRK | got E0 and F0
// PAUSE  | inside the 8-byte E1 pause sequence
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       status_tick,
  output logic [7:0] status_code,
  output logic       overrun_tick,
  output logic       timeout_tick
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pause_q, pause_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_break_q, key_break_d;
  logic             status_tick_q, status_tick_d;
  logic [7:0]       status_code_q, status_code_d;
  logic             overrun_tick_q, overrun_tick_d;
  logic             timeout_tick_q, timeout_tick_d;

  logic       is_e0, is_f0, is_e1, is_status;
  logic       timeout;
  logic       ev_fire, ev_ext, ev_brk, ev_pause, ev_emit, status_hit;
  logic [7:0] ev_code;

  always_comb begin
    is_e0     = (rx_byte == 8'hE0);
    is_f0     = (rx_byte == 8'hF0);
    is_e1     = (rx_byte == 8'hE1);
    is_status = (rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pause_q        <= '0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_ext_q      <= 1'b0;
      key_break_q    <= 1'b0;
      status_tick_q  <= 1'b0;
      status_code_q  <= '0;
      overrun_tick_q <= 1'b0;
      timeout_tick_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pause_q        <= pause_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      key_ext_q      <= key_ext_d;
      key_break_q    <= key_break_d;
      status_tick_q  <= status_tick_d;
      status_code_q  <= status_code_d;
      overrun_tick_q <= overrun_tick_d;
      timeout_tick_q <= timeout_tick_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    cnt_d   = '0;
    timeout = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (is_e0)      state_d = EXT;
          else if (is_f0) state_d = BRK;
          else if (is_e1) begin
            state_d = PAUSE;
            pause_d = 3'd7;
          end
        end
        EXT:     if (is_f0) state_d = EXTBRK; else if (!is_e0) state_d = IDLE;
        BRK:     if (is_e0) state_d = EXTBRK; else if (!is_f0) state_d = IDLE;
        EXTBRK:  if (!is_e0 && !is_f0) state_d = IDLE;
        PAUSE: begin
          pause_d = pause_q - 3'd1;
          if (pause_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ev_fire    = 1'b0;
    ev_code    = rx_byte;
    ev_ext     = 1'b0;
    ev_brk     = 1'b0;
    ev_pause   = 1'b0;
    status_hit = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: if (!is_e0 && !is_f0 && !is_e1) begin
          status_hit = is_status;
          ev_fire    = !is_status;
        end
        EXT: if (!is_e0 && !is_f0) begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
        end
        BRK: if (!is_e0 && !is_f0) begin
          ev_fire = 1'b1;
          ev_brk  = 1'b1;
        end
        EXTBRK: if (!is_e0 && !is_f0) begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
        end
        PAUSE: if (pause_q == 3'd1) begin
          ev_fire  = 1'b1;
          ev_code  = 8'hE1;
          ev_pause = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PS2_SCAN_DECODER_REPEAT_FILTER_EN
  logic       lm_valid_q, lm_valid_d, lm_ext_q, lm_ext_d, lm_match;
  logic [7:0] lm_code_q, lm_code_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= '0;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end

  // Typematic repeats of the last pressed key are swallowed until it is released.
  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    lm_match   = lm_valid_q && (lm_ext_q == ev_ext) && (lm_code_q == ev_code);
    ev_emit    = ev_fire;
    if (timeout) begin
      lm_valid_d = 1'b0;
    end else if (ev_fire && !ev_pause) begin
      if (!ev_brk) begin
        ev_emit    = !lm_match;
        lm_valid_d = 1'b1;
        lm_ext_d   = ev_ext;
        lm_code_d  = ev_code;
      end else if (lm_match) begin
        lm_valid_d = 1'b0;
      end
    end
  end
`else
  always_comb ev_emit = ev_fire;
`endif

  always_comb begin
    key_valid_d    = key_valid_q;
    key_code_d     = key_code_q;
    key_ext_d      = key_ext_q;
    key_break_d    = key_break_q;
    overrun_tick_d = 1'b0;
    status_tick_d  = status_hit;
    status_code_d  = status_hit ? rx_byte : status_code_q;
    timeout_tick_d = timeout;
    if (ev_emit) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = ev_code;
        key_ext_d   = ev_ext;
        key_break_d = ev_brk;
      end else begin
        overrun_tick_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_ext      = key_ext_q;
  assign key_break    = key_break_q;
  assign status_tick  = status_tick_q;
  assign status_code  = status_code_q;
  assign overrun_tick = overrun_tick_q;
  assign timeout_tick = timeout_tick_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus random byte streams against a prefix-flag reference model.
// Honours PS2_SCAN_DECODER_REPEAT_FILTER_EN when defined.
module tb_ps2_scan_decoder;
  localparam int TC = 16;

  logic       clk = 1'b0;
  logic       reset, rx_done_tick, key_ready;
  logic [7:0] rx_byte;
  logic       key_valid, key_ext, key_break, status_tick, overrun_tick, timeout_tick;
  logic [7:0] key_code, status_code;

  ps2_scan_decoder #(.TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_byte(rx_byte),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .status_tick(status_tick),
    .status_code(status_code), .overrun_tick(overrun_tick), .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags, bytes left in a pause sequence, idle gap counter.
  bit         m_valid, m_ext, m_brk, m_ovr, m_stat, m_to;
  logic [7:0] m_code, m_scode;
  bit         p_ext, p_brk;
  int         pause_left, gap;
  bit         lv, le;
  logic [7:0] lc;

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  task automatic model(input bit tick, input logic [7:0] b, input bit rdy, input bit rst);
    bit ev, ee, eb, ep;
    logic [7:0] ec;
    ev = 0; ee = 0; eb = 0; ep = 0; ec = b;
    m_ovr = 0; m_stat = 0; m_to = 0;
    if (rst) begin
      m_valid = 0; m_ext = 0; m_brk = 0; m_code = 0; m_scode = 0;
      p_ext = 0; p_brk = 0; pause_left = 0; gap = 0; lv = 0; le = 0; lc = 0;
      return;
    end
    if (tick) begin
      gap = 0;
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) begin ev = 1; ec = 8'hE1; ep = 1; end
      end else if (b == 8'hE0) p_ext = 1;
      else if (b == 8'hF0) p_brk = 1;
      else if (p_ext || p_brk) begin
        ev = 1; ee = p_ext; eb = p_brk; p_ext = 0; p_brk = 0;
      end else if (b == 8'hE1) pause_left = 7;
      else if (is_status(b)) begin m_stat = 1; m_scode = b; end
      else ev = 1;
    end else if (p_ext || p_brk || pause_left > 0) begin
      if (gap == TC - 1) begin
        p_ext = 0; p_brk = 0; pause_left = 0; gap = 0; m_to = 1; lv = 0;
      end else gap++;
    end
`ifdef PS2_SCAN_DECODER_REPEAT_FILTER_EN
    if (ev && !ep) begin
      if (!eb) begin
        if (lv && le == ee && lc == ec) ev = 0;
        lv = 1; le = ee; lc = ec;
      end else if (lv && le == ee && lc == ec) lv = 0;
    end
`endif
    if (ev) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_code = ec; m_ext = ee; m_brk = eb;
      end else m_ovr = 1;
    end else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic step(input bit tick, input logic [7:0] b, input bit rdy, input bit rst);
    @(negedge clk);
    reset = rst; rx_done_tick = tick; rx_byte = b; key_ready = rdy;
    model(tick, b, rdy, rst);
    @(posedge clk);
    #1;
    chk("key_valid", key_valid, m_valid);
    chk("key_code", key_code, m_code);
    chk("key_ext", key_ext, m_ext);
    chk("key_break", key_break, m_brk);
    chk("overrun_tick", overrun_tick, m_ovr);
    chk("status_tick", status_tick, m_stat);
    chk("status_code", status_code, m_scode);
    chk("timeout_tick", timeout_tick, m_to);
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    logic [7:0] codes [5];
    logic [7:0] stats [8];
    codes = '{8'h1C, 8'h32, 8'h75, 8'h14, 8'h77};
    stats = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    r = int'($urandom_range(0, 99));
    if (r < 12) return 8'hE0;
    if (r < 26) return 8'hF0;
    if (r < 30) return 8'hE1;
    if (r < 37) return stats[$urandom_range(0, 7)];
    if (r < 75) return codes[$urandom_range(0, 4)];
    return 8'($urandom_range(0, 255));
  endfunction

  logic [7:0] flt_seq   [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    int nev, nto;
    reset = 1'b1; rx_done_tick = 1'b0; rx_byte = 8'h00; key_ready = 1'b0;
    step(0, 8'h00, 0, 1);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);

    // repeat filter: emitted events counted with an idle accept cycle after each byte
    nev = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, flt_seq[i], 1, 0);
      if (key_valid) nev++;
      step(0, 8'h00, 1, 0);
    end
`ifdef PS2_SCAN_DECODER_REPEAT_FILTER_EN
    chk("filter_events", nev, 3);
`else
    chk("filter_events", nev, 5);
`endif

    step(0, 8'h00, 0, 1);
    step(1, 8'h1C, 1, 0);
    chk("make_valid", key_valid, 1);
    chk("make_code", key_code, 8'h1C);
    chk("make_brk", key_break, 0);
    step(1, 8'hF0, 1, 0);
    chk("brk_prefix_valid", key_valid, 0);
    step(1, 8'h1C, 1, 0);
    chk("brk_code", key_code, 8'h1C);
    chk("brk_brk", key_break, 1);
    chk("brk_ext", key_ext, 0);

    step(0, 8'h00, 0, 1);
    step(1, 8'hE0, 1, 0);
    step(1, 8'hF0, 1, 0);
    chk("extbrk_prefix_valid", key_valid, 0);
    step(1, 8'h75, 1, 0);
    chk("extbrk_code", key_code, 8'h75);
    chk("extbrk_ext", key_ext, 1);
    chk("extbrk_brk", key_break, 1);

    step(0, 8'h00, 0, 1);
    nev = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, pause_seq[i], 1, 0);
      if (key_valid) nev++;
    end
    chk("pause_early_events", nev, 0);
    step(1, pause_seq[7], 1, 0);
    chk("pause_valid", key_valid, 1);
    chk("pause_code", key_code, 8'hE1);
    chk("pause_ext", key_ext, 0);

    step(0, 8'h00, 0, 1);
    step(1, 8'h1C, 0, 0);
    step(1, 8'h32, 0, 0);
    chk("ovr_tick", overrun_tick, 1);
    chk("ovr_hold_code", key_code, 8'h1C);
    step(0, 8'h00, 0, 0);
    chk("ovr_tick_once", overrun_tick, 0);
    step(0, 8'h00, 1, 0);
    chk("ovr_accept_valid", key_valid, 0);

    step(0, 8'h00, 0, 1);
    step(1, 8'hE0, 1, 0);
    nto = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, 1, 0);
      if (timeout_tick) nto++;
    end
    chk("timeout_pulses", nto, 1);
    step(1, 8'h1C, 1, 0);
    chk("after_to_code", key_code, 8'h1C);
    chk("after_to_ext", key_ext, 0);
    step(1, 8'hAA, 1, 0);
    chk("status_tick_aa", status_tick, 1);
    chk("status_code_aa", status_code, 8'hAA);
    chk("status_no_event", key_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) step(0, 8'h00, 1, 1);
      else if ($urandom_range(0, 99) < 3) begin
        for (int k = 0; k < 20; k++) step(0, 8'h00, bit'($urandom_range(0, 1)), 0);
      end else begin
        step($urandom_range(0, 99) < 40, pick_byte(), $urandom_range(0, 99) < 60, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
